queue_occupancy_tracker: RTL and testbench
==========================================

# queue_occupancy_tracker

Parametrised occupancy tracker for a monitored queue: counts arrivals and departures from two entry/exit sensor levels and reports occupancy, status band, sticky error flags, peak occupancy and a running arrival total. Sits between the sensor synchronisers and the display/alarm logic. Capacity, thresholds and counter widths are generic, so one block serves queues of any size.

## Interface

Parameters:
- MAX_COUNT, 7: queue capacity; legal range ≥ 2.
- CW, $clog2(MAX_COUNT+1): occupancy width.
- ALMOST_FULL, 6: almost-full threshold; legal range 1..MAX_COUNT.
- TW, 16: arrival-total width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- up  in  1  arrival sensor level; one event per 0→1 transition.
- down  in  1  departure sensor level; one event per 0→1 transition.
- clear_err  in  1  clears the sticky overflow and underflow flags.
- clear_peak  in  1  reloads peak from the current pcount.
- pcount  out  CW  current occupancy.
- empty  out  1  pcount == 0.
- full  out  1  pcount == MAX_COUNT.
- almost_full  out  1  pcount ≥ ALMOST_FULL.
- state  out  2  status band: 0 EMPTY, 1 NORMAL, 2 ALMOST, 3 FULL.
- overflow  out  1  sticky; set by a rejected arrival.
- underflow  out  1  sticky; set by a rejected departure.
- reject  out  1  one-cycle pulse when an event is rejected.
- peak  out  CW  maximum pcount since reset or the last clear_peak.
- arrivals_total  out  TW  accepted arrivals, modulo 2^TW.

## Operation

**Edge detection**
- up_q and down_q register the previous sensor level.
- up_evt = up & ~up_q; down_evt = down & ~down_q.
- up_q and down_q reset to 1. A sensor held high through reset therefore produces no event until it falls and rises again.

**Count update**, one per edge, by priority:
- up_evt & down_evt: net zero. pcount is unchanged and arrivals_total increments. No reject and no error, even when pcount is 0 or MAX_COUNT.
- up_evt only, pcount < MAX_COUNT: pcount increments and arrivals_total increments.
- up_evt only, pcount == MAX_COUNT: pcount holds, overflow is set and reject pulses. arrivals_total does not increment.
- down_evt only, pcount > 0: pcount decrements.
- down_evt only, pcount == 0: pcount holds, underflow is set and reject pulses.
- No event: all state holds. reject = 0.

**Flags and counters**
- pcount never leaves 0..MAX_COUNT. No wrap is permitted.
- overflow and underflow are sticky until clear_err. If clear_err coincides with a new error of the same kind, the set wins.
- peak updates to pcount_next whenever pcount_next > peak.
- clear_peak loads peak with pcount_next.
- arrivals_total wraps from 2^TW−1 to 0 silently.

**Combinational decode from registered pcount**
- empty, full and almost_full decode directly from pcount.
- state: FULL if full, else ALMOST if almost_full, else EMPTY if empty, else NORMAL.
- If ALMOST_FULL == MAX_COUNT, the ALMOST band is never shown.

**Reset** (rst high at an edge) overrides all inputs. Reset values:
- pcount=0, empty=1, full=0, almost_full=0, state=0.
- overflow=0, underflow=0, reject=0.
- peak=0, arrivals_total=0.
- up_q=1, down_q=1.
- A reset asserted mid-burst discards any event sampled in that cycle.

## Timing

- A sensor rise sampled at edge N updates pcount, arrivals_total and peak at edge N. These become visible after edge N, i.e. one cycle after the sensor is first high.
- reject is registered: high for exactly the cycle following the rejecting edge.
- overflow and underflow are visible from that same cycle.
- empty, full, almost_full and state carry no extra latency relative to pcount.
- A sensor level held high produces exactly one event.
- Back-to-back events require the sensor to go low for at least one sampled cycle.
- Maximum event rate: one arrival and one departure per two cycles each.

## Test plan

- **Reset and held sensors.** Reset with up=1 held, then hold up=1 for 5 cycles → pcount stays 0, empty=1, arrivals_total=0, no reject.
- **Fill to overflow** (MAX_COUNT=7, ALMOST_FULL=6). Apply 8 up pulses → pcount steps 1..7, almost_full first at pcount 6, full and state=3 at 7. The 8th pulse gives reject for one cycle, overflow=1, pcount=7, arrivals_total=7.
- **Empty underflow.** From reset, one down pulse → underflow=1, reject for one cycle, pcount=0. Then clear_err coincident with a second down pulse → underflow stays 1. clear_err alone → 0.
- **Simultaneous events.** Coincident up and down rises at pcount=0, 3 and 7 → pcount unchanged, arrivals_total+1 each time, no reject, no flag changes.
- **Peak and clear.** Rise to 5, fall to 2 → peak=5. Pulse clear_peak → peak=2. One more up → peak=3.
- **Wrap and mid-operation reset** (TW=4). Apply 20 net-zero up/down pairs → arrivals_total=4 (wrapped past 15). Assert rst during an up rise at pcount=3 → all outputs return to reset values and the arrival is not counted.

Source files
------------

// File: rtl/queue_occupancy_tracker.sv
// queue_occupancy_tracker: edge-detected arrival/departure counter with status band, sticky errors, peak and arrival total
module queue_occupancy_tracker #(
  parameter int MAX_COUNT   = 7,
  parameter int CW          = $clog2(MAX_COUNT + 1),
  parameter int ALMOST_FULL = 6,
  parameter int TW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up,
  input  logic          down,
  input  logic          clear_err,
  input  logic          clear_peak,
  output logic [CW-1:0] pcount,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic [1:0]    state,
  output logic          overflow,
  output logic          underflow,
  output logic          reject,
  output logic [CW-1:0] peak,
  output logic [TW-1:0] arrivals_total
);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);
  localparam logic [CW-1:0] AF_C  = CW'(ALMOST_FULL);
  logic          up_q, down_q, ovf_q, unf_q, rej_q;
  logic          ovf_d, unf_d, rej_d;
  logic [CW-1:0] pcount_q, pcount_d, peak_q, peak_d;
  logic [TW-1:0] total_q, total_d;
  logic          up_evt, down_evt, acc_up, rej_up, acc_dn, rej_dn;
  always_comb begin
    up_evt   = up & ~up_q;
    down_evt = down & ~down_q;
    acc_up   = up_evt & ~down_evt & (pcount_q != MAX_C);
    rej_up   = up_evt & ~down_evt & (pcount_q == MAX_C);
    acc_dn   = down_evt & ~up_evt & (pcount_q != '0);
    rej_dn   = down_evt & ~up_evt & (pcount_q == '0);
    pcount_d = acc_up ? pcount_q + 1'b1 : acc_dn ? pcount_q - 1'b1 : pcount_q;
    total_d  = total_q + TW'((up_evt & down_evt) | acc_up);
    // a new error in the same cycle as clear_err keeps the flag set
    ovf_d    = rej_up | (ovf_q & ~clear_err);
    unf_d    = rej_dn | (unf_q & ~clear_err);
    rej_d    = rej_up | rej_dn;
    peak_d   = (clear_peak || pcount_d > peak_q) ? pcount_d : peak_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      up_q     <= 1'b1;
      down_q   <= 1'b1;
      pcount_q <= '0;
      total_q  <= '0;
      peak_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      up_q     <= up;
      down_q   <= down;
      pcount_q <= pcount_d;
      total_q  <= total_d;
      peak_q   <= peak_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rej_q    <= rej_d;
    end
  end
  always_comb begin
    pcount         = pcount_q;
    empty          = pcount_q == '0;
    full           = pcount_q == MAX_C;
    almost_full    = pcount_q >= AF_C;
    state          = full ? 2'd3 : almost_full ? 2'd2 : empty ? 2'd0 : 2'd1;
    overflow       = ovf_q;
    underflow      = unf_q;
    reject         = rej_q;
    peak           = peak_q;
    arrivals_total = total_q;
  end
endmodule

// File: tb/tb_queue_occupancy_tracker.sv
// tb_queue_occupancy_tracker: scoreboard bench driven by a behavioural occupancy model
module tb_queue_occupancy_tracker;
  localparam int MAXC = 7;
  localparam int AF   = 6;
  localparam int TW   = 4;
  localparam int CW   = 3;
  logic clk = 0, rst = 0, up = 0, down = 0, clear_err = 0, clear_peak = 0;
  logic [CW-1:0] pcount, peak;
  logic [TW-1:0] arrivals_total;
  logic [1:0] state;
  logic empty, full, almost_full, overflow, underflow, reject;
  int checks = 0, errors = 0;
  typedef struct {
    int cnt, emp, ful, af, st, ovf, unf, rej, pk, tot;
  } exp_t;
  exp_t sb[$];
  int m_cnt = 0, m_ovf = 0, m_unf = 0, m_pk = 0, m_tot = 0, m_upl = 1, m_dnl = 1;

  queue_occupancy_tracker #(.MAX_COUNT(MAXC), .ALMOST_FULL(AF), .TW(TW)) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .clear_err(clear_err), .clear_peak(clear_peak),
    .pcount(pcount), .empty(empty), .full(full), .almost_full(almost_full), .state(state),
    .overflow(overflow), .underflow(underflow), .reject(reject), .peak(peak),
    .arrivals_total(arrivals_total)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input int u, input int d, input int ce, input int cp, input int r);
    exp_t e;
    int ue, de, rj;
    @(negedge clk);
    up = u[0]; down = d[0]; clear_err = ce[0]; clear_peak = cp[0]; rst = r[0];
    rj = 0;
    if (r != 0) begin
      m_cnt = 0; m_ovf = 0; m_unf = 0; m_pk = 0; m_tot = 0; m_upl = 1; m_dnl = 1;
    end else begin
      ue = (u != 0 && m_upl == 0) ? 1 : 0;
      de = (d != 0 && m_dnl == 0) ? 1 : 0;
      if (ce != 0) begin m_ovf = 0; m_unf = 0; end
      if (ue == 1 && de == 1) m_tot = (m_tot + 1) % 16;
      else if (ue == 1) begin
        if (m_cnt == MAXC) begin m_ovf = 1; rj = 1; end
        else begin m_cnt++; m_tot = (m_tot + 1) % 16; end
      end else if (de == 1) begin
        if (m_cnt == 0) begin m_unf = 1; rj = 1; end
        else m_cnt--;
      end
      if (cp != 0 || m_cnt > m_pk) m_pk = m_cnt;
      m_upl = u; m_dnl = d;
    end
    e.cnt = m_cnt; e.emp = (m_cnt == 0); e.ful = (m_cnt == MAXC); e.af = (m_cnt >= AF);
    if (m_cnt == MAXC) e.st = 3;
    else if (m_cnt >= AF) e.st = 2;
    else if (m_cnt == 0) e.st = 0;
    else e.st = 1;
    e.ovf = m_ovf; e.unf = m_unf; e.rej = rj; e.pk = m_pk; e.tot = m_tot;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic pulse(input int u, input int d);
    cycle(u, d, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("pcount", 32'(pcount), e.cnt);
      check("empty", 32'(empty), e.emp);
      check("full", 32'(full), e.ful);
      check("almost_full", 32'(almost_full), e.af);
      check("state", 32'(state), e.st);
      check("overflow", 32'(overflow), e.ovf);
      check("underflow", 32'(underflow), e.unf);
      check("reject", 32'(reject), e.rej);
      check("peak", 32'(peak), e.pk);
      check("arrivals_total", 32'(arrivals_total), e.tot);
    end
  end

  initial begin
    // reset with up held high, then keep it high: no event
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    repeat (5) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    // fill to overflow
    repeat (8) pulse(1, 0);
    // empty underflow and clear_err priority
    cycle(0, 0, 0, 0, 1);
    pulse(0, 1);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    // simultaneous events at 0, 3 and 7
    pulse(1, 1);
    repeat (3) pulse(1, 0);
    pulse(1, 1);
    repeat (4) pulse(1, 0);
    pulse(1, 1);
    // peak and clear
    cycle(0, 0, 0, 0, 1);
    repeat (5) pulse(1, 0);
    repeat (3) pulse(0, 1);
    cycle(0, 0, 0, 1, 0);
    pulse(1, 0);
    // total wrap then reset during an arrival
    cycle(0, 0, 0, 0, 1);
    repeat (20) pulse(1, 1);
    repeat (3) pulse(1, 0);
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    pulse(1, 0);
    // random mix
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 9) == 0) ? 1 : 0,
            ($urandom_range(0, 9) == 0) ? 1 : 0, ($urandom_range(0, 49) == 0) ? 1 : 0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
